mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Bus-side responder (slave) for the processor memory interface: accepts MemReq/MemRW/MemAddr/MemData/MemBE from the processor core and returns MemData and MemAck.
- Backs the interface with an internal word-addressed RAM, configurable wait states and byte-enable writes.
- Flags accesses outside its address window.
- Sits between the processor core and the system bus as main memory or as a template for device responders.

Parameters:
BASE_ADDR  32'h0000_0000  byte base address of the window; must be aligned to the window size
ADDR_W  12  word-address width; window = 2^ADDR_W words = 2^(ADDR_W+2) bytes
WAIT_STATES  2  extra cycles inserted before MemAck_O; legal range 0..15

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
MemReq_I  input  1  bus request from processor; held high until acknowledged
MemRW_I  input  1  1 = read cycle, 0 = write cycle
MemAddr_I  input  32  byte address; bits [1:0] ignored
MemData_I  input  32  write data from processor
MemBE_I  input  4  byte enables; bit n selects MemData_I[8n+7:8n]
MemData_O  output  32  read data to processor
MemAck_O  output  1  one-cycle acknowledge
MemErr_O  output  1  high with MemAck_O when the address is outside the window

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- Reset values:
  - MemAck_O = 0, MemErr_O = 0, MemData_O = 32'h0.
  - FSM = IDLE, wait counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - On a rising edge with MemReq_I = 1, latch the address, RW, data and BE.
  - Compute in_range = (MemAddr_I[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - Load counter = WAIT_STATES.
  - Next state: WAIT if WAIT_STATES > 0, else ACK.
- WAIT:
  - Decrement the counter each cycle; go to ACK when the counter reaches 1.
  - If MemReq_I falls in WAIT (protocol violation): abort to IDLE with no ack, no write, and MemData_O unchanged.
- ACK:
  - MemAck_O is high for exactly one cycle.
  - Acceptance edge at cycle t gives MemAck_O high in cycle t+1+WAIT_STATES.
  - Read, in range: MemData_O = RAM[latched word addr], valid in the ack cycle and held until the next completed read. BE is ignored; the full word is returned.
  - Write, in range: for each BE bit set, the byte is committed at the edge that raises MemAck_O. BE = 4'b0000 means no change, but the ack is still given.
  - Out of range: MemErr_O = 1 in the ack cycle. No RAM write. A read returns MemData_O = 32'h0.
  - Next state: HOLD.
- HOLD:
  - MemAck_O = 0.
  - Stay while MemReq_I = 1; go to IDLE on the first cycle with MemReq_I = 0.
  - Back-to-back requests therefore need at least one low cycle of MemReq_I.
- Data consistency:
  - Latched request fields are used throughout; changes on MemAddr_I, MemData_I or MemBE_I after acceptance have no effect.
  - A read following a write to the same word returns the written data, because the write commits before the next acceptance.
- Reset mid-operation: Reset low in WAIT or ACK forces IDLE immediately. Outputs take their reset values, and a not-yet-committed write is dropped.
- Counter: 4 bits wide. WAIT_STATES = 0 bypasses WAIT entirely.

Test Plan:
1. Reset low, then high; write 0x12345678 to BASE+0x10 with BE=4'hF and WAIT_STATES=2 -> MemAck_O high exactly at acceptance+3, MemErr_O=0. A following read of BASE+0x10 returns 0x12345678 in its ack cycle.
2. Write 0xAABBCCDD with BE=4'b0101 over word 0x12345678 -> read returns 0x12BB56DD. A write with BE=0 leaves the word unchanged and is still acked.
3. Read of BASE+(1<<(ADDR_W+2)) (first address past the window) -> ack at normal latency, MemErr_O=1, MemData_O=0. A write to the same address leaves all RAM words unchanged.
4. MemReq_I held high for 5 cycles after ack -> single one-cycle ack pulse, no second transaction. Req low for 1 cycle then high -> new transaction accepted.
5. Reset low during WAIT of a write -> MemAck_O=0 immediately, FSM in IDLE. A later read returns the old data.
6. WAIT_STATES=0: read accepted at t -> ack at t+1. MemReq_I dropped mid-WAIT with WAIT_STATES=3 -> no ack, no write, returns to IDLE.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// Processor memory bus between a requesting core (master) and a memory or
// device responder (slave).
//
// Handshake: the master raises MemReq_I with MemRW_I/MemAddr_I/MemData_I/
// MemBE_I valid and holds it until MemAck_O. MemAck_O is a one-cycle pulse
// with MemErr_O and MemData_O valid in that cycle. The master must then drop
// MemReq_I for at least one cycle before it issues the next request.
interface mem_bus_responder_if;
  logic        MemReq_I;
  logic        MemRW_I;
  logic [31:0] MemAddr_I;
  logic [31:0] MemData_I;
  logic [3:0]  MemBE_I;
  logic [31:0] MemData_O;
  logic        MemAck_O;
  logic        MemErr_O;

  modport master (
    output MemReq_I,
    output MemRW_I,
    output MemAddr_I,
    output MemData_I,
    output MemBE_I,
    input  MemData_O,
    input  MemAck_O,
    input  MemErr_O
  );

  modport slave (
    input  MemReq_I,
    input  MemRW_I,
    input  MemAddr_I,
    input  MemData_I,
    input  MemBE_I,
    output MemData_O,
    output MemAck_O,
    output MemErr_O
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory bus responder: word-addressed RAM behind a base-aligned address
// window, with programmable wait states, byte-enable writes and error acks.
module mem_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_STATES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_bus_responder_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  localparam int          TAG_LSB = ADDR_W + 2;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  WS4     = 4'(WAIT_STATES);

  // Encoding is visible on dbg_state_o: 0 idle, 1 wait, 2 ack, 3 hold.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                in_range_q;
  logic                ack_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem_q [0:DEPTH-1];

  logic [ADDR_W-1:0]   addr_d;
  logic                in_range_d;
  logic                wr_en;
  logic [1:0]          unused_addr_lsb;

  assign addr_d          = bus.MemAddr_I[TAG_LSB-1:2];
  assign in_range_d      = (bus.MemAddr_I[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign unused_addr_lsb = bus.MemAddr_I[1:0];

  // The write lands on the same edge that raises MemAck_O, so a following
  // read can never observe stale data.
  assign wr_en = (state_q == S_ACK) && !rw_q && in_range_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      in_range_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.MemReq_I) begin
            addr_q     <= addr_d;
            rw_q       <= bus.MemRW_I;
            wdata_q    <= bus.MemData_I;
            be_q       <= bus.MemBE_I;
            in_range_q <= in_range_d;
            cnt_q      <= WS4;
            state_q    <= (WS4 != 4'd0) ? S_WAIT : S_ACK;
          end
        end

        S_WAIT: begin
          // Dropping the request before the ack is a protocol violation:
          // abandon the cycle without side effects.
          if (!bus.MemReq_I) begin
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= S_ACK;
            end
          end
        end

        S_ACK: begin
          ack_q <= 1'b1;
          err_q <= !in_range_q;
          if (rw_q) begin
            rdata_q <= in_range_q ? mem_q[addr_q] : 32'h0;
          end
          state_q <= S_HOLD;
        end

        S_HOLD: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (!bus.MemReq_I) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.MemData_O = rdata_q;
  assign bus.MemAck_O  = ack_q;
  assign bus.MemErr_O  = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (2, 0 and 3 wait states)
// driven through one shared master port, checked against a word-map model.
module tb_mem_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          AW   = 12;
  localparam logic [31:0] OOR  = BASE + (32'd1 << (AW + 2));

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared master-side drive, steered to one instance by sel
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  int          sel;

  mem_bus_responder_if bus0 ();
  mem_bus_responder_if bus1 ();
  mem_bus_responder_if bus2 ();

  assign bus0.MemReq_I = req && (sel == 0);
  assign bus1.MemReq_I = req && (sel == 1);
  assign bus2.MemReq_I = req && (sel == 2);
  assign bus0.MemRW_I = rw;    assign bus1.MemRW_I = rw;    assign bus2.MemRW_I = rw;
  assign bus0.MemAddr_I = addr; assign bus1.MemAddr_I = addr; assign bus2.MemAddr_I = addr;
  assign bus0.MemData_I = wdata; assign bus1.MemData_I = wdata; assign bus2.MemData_I = wdata;
  assign bus0.MemBE_I = be;    assign bus1.MemBE_I = be;    assign bus2.MemBE_I = be;

  logic [1:0] st0, st1, st2;

  mem_bus_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_STATES(2)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .bus(bus0.slave), .dbg_state_o(st0));
  mem_bus_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_STATES(0)) u_dut1 (
    .Clk(clk), .Reset(rst_n), .bus(bus1.slave), .dbg_state_o(st1));
  mem_bus_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_STATES(3)) u_dut2 (
    .Clk(clk), .Reset(rst_n), .bus(bus2.slave), .dbg_state_o(st2));

  logic        ack_m;
  logic        err_m;
  logic [31:0] data_m;
  logic [1:0]  st_m;

  always_comb begin
    ack_m = bus0.MemAck_O; err_m = bus0.MemErr_O; data_m = bus0.MemData_O; st_m = st0;
    if (sel == 1) begin
      ack_m = bus1.MemAck_O; err_m = bus1.MemErr_O; data_m = bus1.MemData_O; st_m = st1;
    end else if (sel == 2) begin
      ack_m = bus2.MemAck_O; err_m = bus2.MemErr_O; data_m = bus2.MemData_O; st_m = st2;
    end
  end

  // reference model: RAM as a sparse word map, last completed read per instance
  logic [31:0] mdl [int];
  logic [31:0] last_rd [3];
  int passes = 0;
  int fails  = 0;
  int total  = 0;

  function automatic int ws_of(input int s);
    return (s == 1) ? 0 : ((s == 2) ? 3 : 2);
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return a[31:AW+2] == BASE[31:AW+2];
  endfunction

  function automatic int key_of(input int s, input logic [31:0] a);
    return s * (1 << AW) + int'(a[AW+1:2]);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_last_rd();
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
  endtask

  // driver: one complete transaction, checked against the model
  task automatic do_txn(input int s, input logic is_rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int hold,
                        output logic [31:0] rd_o);
    logic        got;
    int          lat;
    logic [31:0] obs_d;
    logic        obs_e;
    logic [31:0] exp_d;
    logic [31:0] cur;
    logic        inw;
    int          key;
    string       tg;
    inw = in_win(a);
    key = key_of(s, a);
    tg  = $sformatf("s%0d %s a=%h", s, is_rd ? "rd" : "wr", a);
    obs_d = 32'h0;
    obs_e = 1'b0;
    @(negedge clk);
    sel = s; rw = is_rd; addr = a; wdata = d; be = b; req = 1'b1;
    @(posedge clk);
    #1;
    addr = $urandom; wdata = $urandom; be = 4'($urandom_range(0, 15));
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack_m) begin
        got = 1'b1; lat = i; obs_d = data_m; obs_e = err_m;
      end else begin
        @(posedge clk);
      end
    end
    chk32({tg, " latency"}, 32'(lat), 32'(ws_of(s) + 1));
    if (got) begin
      chk32({tg, " err"}, {31'h0, obs_e}, {31'h0, !inw});
      if (is_rd) exp_d = inw ? mdl[key] : 32'h0;
      else       exp_d = last_rd[s];
      chk32({tg, " data"}, obs_d, exp_d);
      if (is_rd) begin
        last_rd[s] = exp_d;
      end else if (inw) begin
        cur = mdl.exists(key) ? mdl[key] : 32'hx;
        for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
        mdl[key] = cur;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk32({tg, " hold ack"}, {31'h0, ack_m}, 32'h0);
      chk32({tg, " hold state"}, {30'h0, st_m}, {30'h0, ST_HOLD});
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    chk32({tg, " ack pulse end"}, {31'h0, ack_m}, 32'h0);
    chk32({tg, " back to idle"}, {30'h0, st_m}, {30'h0, ST_IDLE});
    rd_o = obs_d;
  endtask

  // driver: request withdrawn in the first wait cycle
  task automatic do_abort(input int s, input logic is_rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    string tg;
    tg = $sformatf("s%0d abort %s a=%h", s, is_rd ? "rd" : "wr", a);
    @(negedge clk);
    sel = s; rw = is_rd; addr = a; wdata = d; be = b; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk32({tg, " in wait"}, {30'h0, st_m}, {30'h0, ST_WAIT});
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk32({tg, " no ack"}, {31'h0, ack_m}, 32'h0);
    end
    chk32({tg, " idle"}, {30'h0, st_m}, {30'h0, ST_IDLE});
    chk32({tg, " data kept"}, data_m, last_rd[s]);
  endtask

  logic [31:0] rd;
  logic        r_rw;
  logic [31:0] r_a;

  initial begin
    req = 1'b0; rw = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sel = 0;
    rst_n = 1'b0;
    clear_last_rd();
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk32($sformatf("reset s%0d ack", s), {31'h0, ack_m}, 32'h0);
      chk32($sformatf("reset s%0d err", s), {31'h0, err_m}, 32'h0);
      chk32($sformatf("reset s%0d data", s), data_m, 32'h0);
      chk32($sformatf("reset s%0d state", s), {30'h0, st_m}, {30'h0, ST_IDLE});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // basic write then read-back, 2 wait states
    do_txn(0, 1'b0, BASE + 32'h10, 32'h1234_5678, 4'hF, 0, rd);
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'h0, 0, rd);
    chk32("t1 readback", rd, 32'h1234_5678);

    // byte enables
    do_txn(0, 1'b0, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 0, rd);
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'hF, 0, rd);
    chk32("t2 be merge", rd, 32'h12BB_56DD);
    do_txn(0, 1'b0, BASE + 32'h10, $urandom, 4'h0, 0, rd);
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'h0, 0, rd);
    chk32("t2 be zero", rd, 32'h12BB_56DD);

    // randomized traffic over a small word set
    for (int i = 0; i < 8; i++)
      do_txn(0, 1'b0, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, rd);
    for (int i = 0; i < 24; i++) begin
      r_rw = 1'($urandom_range(0, 1));
      r_a  = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r_a = r_a + OOR;
      do_txn(0, r_rw, r_a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), rd);
    end

    // out-of-window accesses
    do_txn(0, 1'b0, BASE, 32'hCAFE_F00D, 4'hF, 0, rd);
    do_txn(0, 1'b1, OOR, $urandom, 4'hF, 0, rd);
    chk32("t3 oor read data", rd, 32'h0);
    do_txn(0, 1'b0, OOR, $urandom, 4'hF, 0, rd);
    do_txn(0, 1'b0, OOR + 32'h10, $urandom, 4'hF, 0, rd);
    do_txn(0, 1'b1, 32'h8000_0010, $urandom, 4'hF, 0, rd);
    do_txn(0, 1'b1, BASE, $urandom, 4'hF, 0, rd);
    chk32("t3 no alias word0", rd, 32'hCAFE_F00D);
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'hF, 0, rd);
    chk32("t3 no alias word4", rd, 32'h12BB_56DD);

    // request held after ack, then re-request after one low cycle
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'hF, 5, rd);
    do_txn(0, 1'b1, BASE, $urandom, 4'hF, 0, rd);
    chk32("t4 next txn", rd, 32'hCAFE_F00D);

    // zero wait states
    do_txn(1, 1'b0, BASE + 32'h20, $urandom, 4'hF, 0, rd);
    do_txn(1, 1'b1, BASE + 32'h20, $urandom, 4'hF, 0, rd);
    for (int i = 0; i < 6; i++)
      do_txn(1, 1'($urandom_range(0, 1)), BASE + 32'h20, $urandom,
             4'($urandom_range(0, 15)), 0, rd);

    // aborted requests, 3 wait states
    do_txn(2, 1'b0, BASE + 32'h40, 32'h0102_0304, 4'hF, 0, rd);
    do_txn(2, 1'b1, BASE + 32'h40, $urandom, 4'hF, 0, rd);
    do_abort(2, 1'b0, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    do_txn(2, 1'b0, BASE + 32'h44, 32'h5555_AAAA, 4'hF, 0, rd);
    do_abort(2, 1'b1, BASE + 32'h44, $urandom, 4'hF);
    do_txn(2, 1'b1, BASE + 32'h40, $urandom, 4'hF, 0, rd);
    chk32("t6 abort no write", rd, 32'h0102_0304);

    // reset during WAIT of a write
    @(negedge clk);
    sel = 0; rw = 1'b0; addr = BASE + 32'h10; wdata = 32'hDEAD_BEEF; be = 4'hF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk32("t5 in wait", {30'h0, st_m}, {30'h0, ST_WAIT});
    rst_n = 1'b0;
    #1;
    chk32("t5 rst ack", {31'h0, ack_m}, 32'h0);
    chk32("t5 rst state", {30'h0, st_m}, {30'h0, ST_IDLE});
    chk32("t5 rst data", data_m, 32'h0);
    req = 1'b0;
    clear_last_rd();
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(0, 1'b1, BASE + 32'h10, $urandom, 4'hF, 0, rd);
    chk32("t5 old data", rd, 32'h12BB_56DD);

    // reset during ACK of a write, zero wait states
    do_txn(1, 1'b0, BASE + 32'h24, 32'h7777_8888, 4'hF, 0, rd);
    @(negedge clk);
    sel = 1; rw = 1'b0; addr = BASE + 32'h24; wdata = 32'h1111_2222; be = 4'hF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk32("t5b in ack", {30'h0, st_m}, {30'h0, ST_ACK});
    rst_n = 1'b0;
    #1;
    chk32("t5b rst ack", {31'h0, ack_m}, 32'h0);
    chk32("t5b rst state", {30'h0, st_m}, {30'h0, ST_IDLE});
    req = 1'b0;
    clear_last_rd();
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1, 1'b1, BASE + 32'h24, $urandom, 4'hF, 0, rd);
    chk32("t5b write dropped", rd, 32'h7777_8888);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
